// File: rtl/rgb_led_arbiter_if.sv
// rgb_led_arbiter_if: requester-side request/color bundle and LED/grant outputs of the arbiter.
interface rgb_led_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req, grant, done;
  logic [3*NUM_REQ-1:0] color;
  logic busy, RGB_R, RGB_G, RGB_B;
  modport master (output req, color, input grant, done, busy, RGB_R, RGB_G, RGB_B);
  modport slave (input req, color, output grant, done, busy, RGB_R, RGB_G, RGB_B);
endinterface

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin sharing of one RGB LED with fixed dwell, blanking gap and PWM dimming.
module rgb_led_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWELL = 2000000,
  parameter int GAP = 200000,
  parameter int DUTY = 256
) (
  input logic clk,
  input logic rst,
  rgb_led_arbiter_if.slave bus
);
  localparam int CW = $clog2((DWELL > GAP ? DWELL : GAP) + 1);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [2:0] col_q, col_d;
  logic [7:0] pwm_q;
  logic last_show;
  int idx;
  assign last_show = state_q == ST_SHOW && cnt_q == CW'(DWELL - 1);
  // descending scan so the requester closest at/after ptr is the one left in pick
  always_comb begin
    pick = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req[idx]) pick = IW'(idx);
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    col_d = col_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|bus.req) begin
          state_d = ST_SHOW;
          gnt_d = pick;
          col_d = bus.color[3*pick +: 3];
        end
      end
      ST_SHOW: if (last_show) begin
        cnt_d = '0;
        ptr_d = gnt_q == IW'(NUM_REQ - 1) ? '0 : gnt_q + IW'(1);
        state_d = GAP > 0 ? ST_GAP : ST_IDLE;
      end
      ST_GAP: if (cnt_q == CW'(GAP - 1)) begin
        cnt_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      gnt_q <= '0;
      col_q <= '0;
      pwm_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      col_q <= col_d;
      pwm_q <= pwm_q + 8'd1;
    end
  end
  assign bus.grant = state_q == ST_SHOW ? NUM_REQ'(1) << gnt_q : '0;
  assign bus.done = last_show ? NUM_REQ'(1) << gnt_q : '0;
  assign bus.busy = state_q != ST_IDLE;
  assign {bus.RGB_R, bus.RGB_G, bus.RGB_B} = state_q == ST_SHOW && {1'b0, pwm_q} < 9'(DUTY) ? col_q : 3'b000;
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed vectors for round-robin grants, dwell/gap timing, latching, reset and PWM.
module tb_rgb_led_arbiter;
  logic clk = 0, rst = 1;
  int errs = 0, checks = 0, cyc = 0, last_start = 0;
  logic [7:0] ref_pwm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk or posedge rst) ref_pwm <= rst ? 8'd0 : ref_pwm + 8'd1;
  rgb_led_arbiter_if #(.NUM_REQ(4)) m_if ();
  rgb_led_arbiter_if #(.NUM_REQ(4)) p_if ();
  rgb_led_arbiter_if #(.NUM_REQ(4)) d_if ();
  rgb_led_arbiter #(.NUM_REQ(4), .DWELL(8), .GAP(2), .DUTY(256)) dut (.clk(clk), .rst(rst), .bus(m_if.slave));
  rgb_led_arbiter #(.NUM_REQ(4), .DWELL(512), .GAP(2), .DUTY(64)) dut_p (.clk(clk), .rst(rst), .bus(p_if.slave));
  rgb_led_arbiter #(.NUM_REQ(4), .DWELL(8), .GAP(2), .DUTY(0)) dut_d (.clk(clk), .rst(rst), .bus(d_if.slave));
  wire [2:0] m_rgb = {m_if.RGB_R, m_if.RGB_G, m_if.RGB_B};
  wire [2:0] p_rgb = {p_if.RGB_R, p_if.RGB_G, p_if.RGB_B};
  wire [2:0] d_rgb = {d_if.RGB_R, d_if.RGB_G, d_if.RGB_B};
  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [2:0] rgb;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_grant(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (m_if.grant == 0 && w < 40);
  endtask
  task automatic serve(input logic [3:0] r, input logic [3:0] eg, input logic [2:0] ergb, input bit spc);
    int w, n, dn, bad;
    logic [3:0] dv;
    m_if.req = r;
    wait_grant(w);
    chk("grant_start", m_if.grant, eg);
    chk("rgb_start", m_rgb, ergb);
    if (spc) chk("start_spacing", cyc - last_start, 11);
    last_start = cyc;
    n = 0; dn = 0; dv = 0; bad = 0;
    while (m_if.grant == eg && n < 20) begin
      n++;
      if (m_if.done != 0) begin
        dn = n;
        dv = m_if.done;
      end
      if (m_rgb != ergb || !m_if.busy) bad++;
      @(negedge clk);
    end
    chk("dwell_len", n, 8);
    chk("done_cycle", dn, 8);
    chk("done_val", dv, eg);
    chk("show_hold", bad, 0);
    chk("gap1", {m_if.busy, m_rgb, m_if.grant, m_if.done}, {1'b1, 11'b0});
    @(negedge clk);
    chk("gap2", {m_if.busy, m_rgb, m_if.grant}, {1'b1, 7'b0});
    @(negedge clk);
    chk("idle", {m_if.busy, m_if.grant}, 5'b0);
  endtask
  initial begin
    int w, n, dn, bad, on, dc;
    tbl[0] = '{4'b0001, 4'b0001, 3'b100};
    tbl[1] = '{4'b0001, 4'b0001, 3'b100};
    tbl[2] = '{4'b1111, 4'b0010, 3'b010};
    tbl[3] = '{4'b1111, 4'b0100, 3'b001};
    tbl[4] = '{4'b1111, 4'b1000, 3'b111};
    tbl[5] = '{4'b1111, 4'b0001, 3'b100};
    tbl[6] = '{4'b0010, 4'b0010, 3'b010};
    tbl[7] = '{4'b0101, 4'b0100, 3'b001};
    tbl[8] = '{4'b0101, 4'b0001, 3'b100};
    tbl[9] = '{4'b1000, 4'b1000, 3'b111};
    tbl[10] = '{4'b0110, 4'b0010, 3'b010};
    m_if.req = 0; p_if.req = 0; d_if.req = 0;
    m_if.color = {3'b111, 3'b001, 3'b010, 3'b100};
    p_if.color = 12'hfff;
    d_if.color = 12'hfff;
    repeat (3) @(negedge clk);
    chk("reset_state", {m_if.grant, m_if.done, m_if.busy, m_rgb}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) serve(tbl[i].req, tbl[i].g, tbl[i].rgb, i > 0);
    // color change and request drop mid-show must not disturb the latched grant
    m_if.req = 4'b0001;
    wait_grant(w);
    chk("latch_grant", m_if.grant, 4'b0001);
    n = 0; dn = 0; bad = 0;
    while (m_if.grant == 4'b0001 && n < 20) begin
      n++;
      if (n == 3) begin
        m_if.color[2:0] = 3'b011;
        m_if.req = 0;
      end
      if (m_if.done != 0) dn = n;
      if (m_rgb != 3'b100) bad++;
      @(negedge clk);
    end
    chk("latch_dwell", n, 8);
    chk("latch_done", dn, 8);
    chk("latch_rgb", bad, 0);
    bad = 0;
    repeat (6) begin
      if (m_if.grant != 0) bad++;
      @(negedge clk);
    end
    chk("no_regrant", bad, 0);
    m_if.color[2:0] = 3'b100;
    m_if.req = 4'b1111;
    wait_grant(w);
    chk("pre_reset_grant", m_if.grant, 4'b0010);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 chk("reset_mid_show", {m_if.grant, m_if.done, m_if.busy, m_rgb}, 0);
    @(negedge clk);
    rst = 0;
    wait_grant(w);
    chk("post_reset_grant", m_if.grant, 4'b0001);
    m_if.req = 0;
    d_if.req = 4'b0001;
    w = 0;
    do begin @(negedge clk); w++; end while (d_if.grant == 0 && w < 40);
    d_if.req = 0;
    n = 0; dc = 0; bad = 0;
    repeat (14) begin
      if (d_if.grant == 4'b0001) n++;
      if (d_if.done != 0) dc++;
      if (d_rgb != 0) bad++;
      @(negedge clk);
    end
    chk("dark_dwell", n, 8);
    chk("dark_done", dc, 1);
    chk("dark_rgb", bad, 0);
    p_if.req = 4'b0001;
    w = 0;
    do begin @(negedge clk); w++; end while (p_if.grant == 0 && w < 40);
    p_if.req = 0;
    n = 0; dc = 0; bad = 0; on = 0;
    while (p_if.grant == 4'b0001 && n < 600) begin
      n++;
      if (p_if.done != 0) dc++;
      if (p_rgb != (ref_pwm < 8'd64 ? 3'b111 : 3'b000)) bad++;
      if (p_rgb != 0) on++;
      @(negedge clk);
    end
    chk("pwm_dwell", n, 512);
    chk("pwm_done", dc, 1);
    chk("pwm_pattern", bad, 0);
    chk("pwm_on_cycles", on, 128);
    chk("pwm_dark_after", p_rgb, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the single on-board RGB LED among up to NUM_REQ independent requesters, such as a heartbeat, a status display and an alert source. Each winning requester gets the LED for a fixed dwell period at its latched color, dimmed by a free-running PWM. A blanking gap separates grants. Grants are issued round-robin, so no requester starves. The block sits between the color-producing logic and the top-level RGB_R/RGB_G/RGB_B pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DWELL, 2000000: clock cycles each grant drives the LED, ≥ 1.
- GAP, 200000: blank cycles after each grant, ≥ 0 (0 means no gap state).
- DUTY, 256: LED-on cycles per 256-cycle PWM period, 0..256 (256 means always on, 0 means always dark).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- color  in  3*NUM_REQ  requester i color at [3i+2:3i], ordered {R,G,B}.
- grant  out  NUM_REQ  one-hot; high for the whole SHOW period of the granted requester.
- done  out  NUM_REQ  one-cycle pulse on the last SHOW cycle of the granted requester.
- busy  out  1  high in SHOW or GAP.
- RGB_R, RGB_G, RGB_B  out  1 each  LED drives, active-high.

## Operation
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - If req is nonzero, pick the first set bit at or after ptr, wrapping modulo NUM_REQ.
  - Latch that requester's color into col_q, set gnt_q to the chosen index, clear cnt, and go to SHOW.
  - If req is zero, stay in IDLE.
- SHOW:
  - cnt increments each cycle.
  - When cnt == DWELL-1: done[gnt_q] = 1 for that cycle, ptr <= (gnt_q+1) mod NUM_REQ, and cnt <= 0.
  - Then go to GAP if GAP > 0, else to IDLE.
- GAP:
  - cnt increments each cycle; LED is dark.
  - When cnt == GAP-1, go to IDLE.
- req is sampled only in IDLE. Dropping req or changing color during SHOW or GAP has no effect, and the show always runs the full DWELL.
- The requester handshake is level-based. A requester that keeps req high is re-granted only after every other active requester has been served.
- PWM: pwm_cnt is 8 bits, free-running from reset and wrapping 255→0. It is independent of grants.
- pwm_on = (pwm_cnt < DUTY). Compare at 9 bits so that DUTY = 256 gives constant on.
- Outputs: {RGB_R,RGB_G,RGB_B} = (state == SHOW && pwm_on) ? col_q : 3'b000.
- grant = (state == SHOW) ? onehot(gnt_q) : 0.
- busy = (state != IDLE).
- cnt width is $clog2(max(DWELL,GAP)+1). Wrap is never reached because the terminal compare resets cnt.
- Reset (asynchronous, at any time, including mid-SHOW or mid-GAP) sets:
  - state = IDLE, cnt = 0, ptr = 0, gnt_q = 0, col_q = 0, pwm_cnt = 0.
  - All outputs 0 immediately, with no done pulse.

## Timing
- Request sampled in IDLE at edge k: grant, busy and LED are valid after edge k. The request-to-LED latency is 1 cycle.
- SHOW lasts exactly DWELL cycles, and done coincides with the last of them.
- GAP lasts exactly GAP cycles. The minimum spacing between grant starts is DWELL+GAP+1 cycles, because IDLE always lasts at least one cycle.
- The granted index is decided only in IDLE, so simultaneous requests are never a conflict: round-robin order resolves them.
- done and the final SHOW cycle are the same cycle. grant falls on the next edge.
- Outputs are combinational decodes of registers only, with no input-to-output combinational path.

## Test plan
All scenarios use NUM_REQ=4, DWELL=8, GAP=2, DUTY=256 unless noted.
- Reset: assert rst mid-SHOW with req=1111 → grant, done, busy and RGB are 0 immediately. After release, the first grant goes to requester 0 (ptr reset).
- Single request: req=0001, color0=100 → grant=0001 and RGB=100 for exactly 8 cycles, done[0] on cycle 8, then 2 dark cycles with busy=1, then 1 IDLE cycle, then re-grant to requester 0.
- Round-robin: req=1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, with starts spaced 11 cycles apart.
- Pointer skip: after requester 1 is served, req=0101 → requester 2 is granted next, then requester 0.
- Latch and drop: change color0 from 100 to 011 and drop req[0] at SHOW cycle 3 → RGB stays 100 for all 8 cycles, and done[0] still pulses.
- PWM: DWELL=512, DUTY=64 → during SHOW, RGB is on 64 of each 256 cycles, aligned to pwm_cnt 0..63. With DUTY=0, RGB stays 000 throughout and grant/done behave unchanged.
